// File: rtl/isqrt_seq_pkg.sv
// Shared definitions for the sequential integer square root.
// Holds the FSM state encoding, the root-width derivation and the
// legality test for the radicand width.
package isqrt_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Root width is always half the radicand width.
  function automatic int root_w_of(input int width);
    return width / 2;
  endfunction

  // Radicand must split into whole 2-bit digits, and at least one of them.
  function automatic bit width_ok(input int width);
    return ((width % 2) == 0) && (width >= 2);
  endfunction

endpackage

// File: rtl/isqrt_seq_if.sv
// Start/done bus of the square-root block.
// Ports: start, radicand (requester -> block); busy, done, root, rem (block -> requester).
// master = requester side, slave = the isqrt_seq block.
interface isqrt_seq_if
  import isqrt_seq_pkg::*;
#(
  parameter int WIDTH = 14
);
  localparam int ROOT_W = root_w_of(WIDTH);

  logic              start;
  logic [WIDTH-1:0]  radicand;
  logic              busy;
  logic              done;
  logic [ROOT_W-1:0] root;
  logic [ROOT_W:0]   rem;

  modport master (
    output start, radicand,
    input  busy, done, root, rem
  );

  modport slave (
    input  start, radicand,
    output busy, done, root, rem
  );

endinterface

// File: rtl/isqrt_step.sv
// One restoring square-root iteration: consumes two radicand bits, yields one root bit.
// Purely combinational, zero latency; no handshake.
// Ports: rem_in/root_in (working state), bits_in (next radicand digit) -> rem_out/root_out.
module isqrt_step #(
  parameter int ROOT_W = 7
) (
  input  logic [ROOT_W+1:0] rem_in,
  input  logic [ROOT_W-1:0] root_in,
  input  logic [1:0]        bits_in,
  output logic [ROOT_W+1:0] rem_out,
  output logic [ROOT_W-1:0] root_out
);

  logic [ROOT_W+1:0] t;
  logic [ROOT_W+1:0] trial;

  always_comb begin
    // The working remainder never exceeds 2*root, so shifting it left by two
    // loses only zero bits; t always fits in ROOT_W+2 bits.
    t     = (rem_in << 2) | (ROOT_W + 2)'(bits_in);
    trial = {root_in, 2'b01};
    if (t >= trial) begin
      rem_out  = t - trial;
      root_out = (root_in << 1) | ROOT_W'(1);
    end else begin
      rem_out  = t;
      root_out = root_in << 1;
    end
  end

endmodule

// File: rtl/isqrt_seq.sv
// Sequential floor square root of a WIDTH-bit radicand, one root bit per clock.
// Latency: done pulses ROOT_W cycles after the accepting edge; one result per ROOT_W+1 clocks.
// Backpressure: none; start is ignored while busy, accepted in IDLE or DONE (back-to-back).
// Ports: clk, rst_n (async active-low); bus = slave side of isqrt_seq_if.
module isqrt_seq
  import isqrt_seq_pkg::*;
#(
  parameter int WIDTH = 14
) (
  input logic        clk,
  input logic        rst_n,
  isqrt_seq_if.slave bus
);

  localparam int ROOT_W = root_w_of(WIDTH);
  localparam int CNT_W  = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;

  if (!width_ok(WIDTH)) begin : g_width_chk
    $error("isqrt_seq: WIDTH must be even and >= 2");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  sr_q, sr_d;
  logic [ROOT_W-1:0] root_w_q, root_w_d;
  logic [ROOT_W+1:0] rem_w_q, rem_w_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ROOT_W-1:0] root_q, root_d;
  logic [ROOT_W:0]   rem_q, rem_d;

  logic [ROOT_W+1:0] step_rem;
  logic [ROOT_W-1:0] step_root;

  isqrt_step #(.ROOT_W(ROOT_W)) u_step (
    .rem_in   (rem_w_q),
    .root_in  (root_w_q),
    .bits_in  (sr_q[WIDTH-1:WIDTH-2]),
    .rem_out  (step_rem),
    .root_out (step_root)
  );

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    root_w_d = root_w_q;
    rem_w_d  = rem_w_q;
    cnt_d    = cnt_q;
    root_d   = root_q;
    rem_d    = rem_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          sr_d     = bus.radicand;
          root_w_d = '0;
          rem_w_d  = '0;
          cnt_d    = CNT_W'(ROOT_W - 1);
          state_d  = ST_CALC;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_CALC: begin
        sr_d     = sr_q << 2;
        root_w_d = step_root;
        rem_w_d  = step_rem;
        cnt_d    = cnt_q - 1'b1;
        // Last digit: publish the result. Outputs stay frozen until the next one.
        if (cnt_q == '0) begin
          root_d  = step_root;
          rem_d   = step_rem[ROOT_W:0];
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sr_q     <= '0;
      root_w_q <= '0;
      rem_w_q  <= '0;
      cnt_q    <= '0;
      root_q   <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      root_w_q <= root_w_d;
      rem_w_q  <= rem_w_d;
      cnt_q    <= cnt_d;
      root_q   <= root_d;
      rem_q    <= rem_d;
    end
  end

  assign bus.busy = (state_q == ST_CALC);
  assign bus.done = (state_q == ST_DONE);
  assign bus.root = root_q;
  assign bus.rem  = rem_q;

endmodule

// File: tb/tb_isqrt_seq.sv
module tb_isqrt_seq;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  isqrt_seq_if #(.WIDTH(14)) bus ();

  isqrt_seq #(.WIDTH(14)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and wait (bounded) for done. lat counts rising edges after
  // the accepting edge; busy_n counts cycles with busy high before done.
  task automatic run_op(input logic [13:0] v, output int lat, output int busy_n,
                        output logic [6:0] r, output logic [7:0] m, output logic to);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.radicand = v;
    @(negedge clk);
    bus.start = 1'b0;
    lat    = 0;
    busy_n = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      if (bus.busy === 1'b1) busy_n++;
      @(negedge clk);
      lat++;
    end
    to = (bus.done !== 1'b1);
    r  = bus.root;
    m  = bus.rem;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.radicand = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_fail++; $display("FAIL reset_flags busy/done=%b required 00", {bus.busy, bus.done});
    end
    n_checks++;
    if (bus.root !== 7'd0 || bus.rem !== 8'd0) begin
      n_fail++; $display("FAIL reset_result root=%0d rem=%0d required 0/0", bus.root, bus.rem);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle busy=%b required 0", bus.busy);
    end
  endtask

  task automatic test_zero();
    int lat, busy_n;
    logic [6:0] r;
    logic [7:0] m;
    logic to;
    run_op(14'd0, lat, busy_n, r, m, to);
    n_checks++;
    if (to !== 1'b0 || lat != 7) begin
      n_fail++; $display("FAIL zero_latency lat=%0d timeout=%b required 7", lat, to);
    end
    n_checks++;
    if (busy_n != 7) begin
      n_fail++; $display("FAIL zero_busy cycles=%0d required 7", busy_n);
    end
    n_checks++;
    if (r !== 7'd0 || m !== 8'd0) begin
      n_fail++; $display("FAIL zero_result root=%0d rem=%0d required 0/0", r, m);
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++; $display("FAIL done_pulse_width done=%b required 0", bus.done);
    end
  endtask

  task automatic test_squares();
    logic [13:0] vv [3] = '{14'd49, 14'd50, 14'd36};
    logic [6:0]  er [3] = '{7'd7, 7'd7, 7'd6};
    logic [7:0]  em [3] = '{8'd0, 8'd1, 8'd0};
    for (int i = 0; i < 3; i++) begin
      int lat, busy_n;
      logic [6:0] r;
      logic [7:0] m;
      logic to;
      run_op(vv[i], lat, busy_n, r, m, to);
      n_checks++;
      if (to !== 1'b0 || r !== er[i] || m !== em[i]) begin
        n_fail++;
        $display("FAIL squares v=%0d root=%0d rem=%0d timeout=%b required %0d/%0d",
                 vv[i], r, m, to, er[i], em[i]);
      end
    end
  endtask

  task automatic test_max();
    int lat, busy_n;
    logic [6:0] r;
    logic [7:0] m;
    logic to;
    run_op(14'd16383, lat, busy_n, r, m, to);
    n_checks++;
    if (to !== 1'b0 || r !== 7'd127 || m !== 8'd254) begin
      n_fail++; $display("FAIL max_value root=%0d rem=%0d timeout=%b required 127/254", r, m, to);
    end
  endtask

  task automatic test_start_ignored();
    int dones;
    logic [6:0] r;
    logic [7:0] m;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.radicand = 14'd100;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start    = 1'b1;
    bus.radicand = 14'd9;
    @(negedge clk);
    // Previous result (16383) must still be presented mid-calculation.
    n_checks++;
    if (bus.busy !== 1'b1 || bus.root !== 7'd127 || bus.rem !== 8'd254) begin
      n_fail++;
      $display("FAIL hold_outputs busy=%b root=%0d rem=%0d required 1/127/254",
               bus.busy, bus.root, bus.rem);
    end
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    r = '0;
    m = '0;
    for (int i = 0; i < 15; i++) begin
      if (bus.done === 1'b1) begin
        dones++;
        r = bus.root;
        m = bus.rem;
      end
      @(negedge clk);
    end
    n_checks++;
    if (dones != 1) begin
      n_fail++; $display("FAIL ignore_start done_pulses=%0d required 1", dones);
    end
    n_checks++;
    if (r !== 7'd10 || m !== 8'd0) begin
      n_fail++; $display("FAIL ignore_start_result root=%0d rem=%0d required 10/0", r, m);
    end
  endtask

  task automatic test_back_to_back();
    int lat, gap;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.radicand = 14'd1000;
    @(negedge clk);
    bus.radicand = 14'd225;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (bus.done !== 1'b1 || bus.root !== 7'd31 || bus.rem !== 8'd39) begin
      n_fail++;
      $display("FAIL b2b_first done=%b root=%0d rem=%0d required 1/31/39",
               bus.done, bus.root, bus.rem);
    end
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
      if (gap == 1) bus.start = 1'b0;
    end while (bus.done !== 1'b1 && gap < 20);
    n_checks++;
    if (gap != 8) begin
      n_fail++; $display("FAIL b2b_spacing cycles=%0d required 8", gap);
    end
    n_checks++;
    if (bus.root !== 7'd15 || bus.rem !== 8'd0) begin
      n_fail++; $display("FAIL b2b_second root=%0d rem=%0d required 15/0", bus.root, bus.rem);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.radicand = 14'd5000;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.root !== 7'd0 || bus.rem !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_abort busy=%b done=%b root=%0d rem=%0d required 0/0/0/0",
               bus.busy, bus.done, bus.root, bus.rem);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    n_checks++;
    if (dones != 0) begin
      n_fail++; $display("FAIL reset_no_done done_pulses=%0d required 0", dones);
    end
  endtask

  // Square-boundary neighbourhoods plus a strided sweep of the whole range,
  // each checked against root*root+rem == v and rem <= 2*root.
  task automatic test_sweep();
    int vals [$];
    for (int k = 0; k <= 128; k++) begin
      for (int d = -1; d <= 1; d++) begin
        if (k * k + d >= 0 && k * k + d < 16384) vals.push_back(k * k + d);
      end
    end
    for (int v = 0; v < 16384; v += 7) vals.push_back(v);
    vals.push_back(16383);
    foreach (vals[i]) begin
      int lat, busy_n, ri, mi;
      logic [6:0] r;
      logic [7:0] m;
      logic to;
      run_op(14'(vals[i]), lat, busy_n, r, m, to);
      ri = int'(r);
      mi = int'(m);
      n_checks++;
      if (to !== 1'b0 || ri * ri + mi != vals[i] || mi > 2 * ri) begin
        n_fail++;
        $display("FAIL sweep v=%0d root=%0d rem=%0d timeout=%b required root^2+rem=v, rem<=2*root",
                 vals[i], ri, mi, to);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_zero();
    test_squares();
    test_max();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
